btn_cmd_sequencer: RTL and testbench

- Turns debounced button levels (one debouncer per button, upstream) into a queue of one-shot command tokens.
- Round-robin arbitrates simultaneous presses and buffers tokens in a small FIFO.
- Offers the tokens to one downstream consumer over a valid/ready handshake, e.g. the camera register-write or mode-change logic.
- Detects lost presses and stalled consumers, and reports both as sticky error flags.

---
 rtl/btn_cmd_sequencer.sv | 162 ++++++++++++++++
 tb/tb_btn_cmd_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/btn_cmd_sequencer.sv
// Debounced button levels to one-shot command tokens: edge detect, round-robin
// arbitration into a small FIFO, valid/ready output with ack timeout and sticky errors.
//
// state | meaning
// IDLE  | FIFO empty, cmd_valid low, timeout counter held at 0
// OFFER | head presented on cmd_valid/cmd_id, waiting for cmd_ready
// DROP  | one cycle with cmd_valid low: head discarded, timeout_err raised
module btn_cmd_sequencer #(
   parameter int NUM_BTNS    = 4,
   parameter int CMD_W       = 2,
   parameter int FIFO_DEPTH  = 4,
   parameter int ACK_TIMEOUT = 1024
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NUM_BTNS-1:0]         btn_down,
   output logic                        cmd_valid,
   output logic [CMD_W-1:0]            cmd_id,
   input  logic                        cmd_ready,
   output logic [$clog2(FIFO_DEPTH):0] fifo_count,
   output logic                        overflow_err,
   output logic                        timeout_err,
   input  logic                        clr_err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int TO_W  = (ACK_TIMEOUT > 0) ? $clog2(ACK_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, OFFER, DROP} stateT;

   stateT               state, stateNext;
   logic [NUM_BTNS-1:0] btnPrev, rise, pending, grantVec;
   logic [CMD_W-1:0]    rrPtr, grantIdx;
   logic                grantValid;
   logic [CMD_W-1:0]    mem [FIFO_DEPTH];
   logic [PTR_W-1:0]    wrPtr, rdPtr;
   logic [CNT_W-1:0]    count, countNext;
   logic [TO_W-1:0]     toCnt, toCntNext;
   logic                push, pop, fifoFull, ovfEvent, dropEvent;

   assign rise       = btn_down & ~btnPrev;
   assign fifoFull   = (count == CNT_W'(FIFO_DEPTH));
   assign push       = grantValid;
   assign pop        = ((state == OFFER) && cmd_ready) || (state == DROP);
   assign ovfEvent   = |(rise & pending & ~grantVec);
   assign cmd_id     = mem[rdPtr];
   assign fifo_count = count;

   // Round-robin search starting at rrPtr; room is judged on the pre-edge count.
   always_comb begin
      logic [CMD_W:0]   idx;
      logic [CMD_W-1:0] sel;
      grantValid = 1'b0;
      grantIdx   = '0;
      grantVec   = '0;
      idx        = '0;
      sel        = '0;
      for (int k = 0; k < NUM_BTNS; k++) begin
         idx = {1'b0, rrPtr} + (CMD_W+1)'(k);
         if (idx >= (CMD_W+1)'(NUM_BTNS))
            idx = idx - (CMD_W+1)'(NUM_BTNS);
         sel = idx[CMD_W-1:0];
         if (!grantValid && !fifoFull && pending[sel]) begin
            grantValid    = 1'b1;
            grantIdx      = sel;
            grantVec[sel] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         btnPrev <= '1;
         pending <= '0;
         rrPtr   <= '0;
      end else begin
         btnPrev <= btn_down;
         pending <= (pending & ~grantVec) | rise;
         if (grantValid)
            rrPtr <= (grantIdx == CMD_W'(NUM_BTNS - 1)) ? '0 : grantIdx + CMD_W'(1);
      end
   end

   always_comb begin
      countNext = count;
      if (push && !pop)
         countNext = count + CNT_W'(1);
      else if (!push && pop)
         countNext = count - CNT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < FIFO_DEPTH; i++)
            mem[i] <= '0;
         wrPtr <= '0;
         rdPtr <= '0;
         count <= '0;
      end else begin
         if (push) begin
            mem[wrPtr] <= grantIdx;
            wrPtr      <= wrPtr + PTR_W'(1);
         end
         if (pop)
            rdPtr <= rdPtr + PTR_W'(1);
         count <= countNext;
      end
   end

   // Next state looks at countNext so a push in IDLE raises cmd_valid one edge later.
   always_comb begin
      stateNext = state;
      toCntNext = toCnt;
      cmd_valid = 1'b0;
      dropEvent = 1'b0;
      case (state)
         IDLE: begin
            toCntNext = '0;
            if (countNext != '0)
               stateNext = OFFER;
         end
         OFFER: begin
            cmd_valid = 1'b1;
            if (cmd_ready) begin
               toCntNext = '0;
               stateNext = (countNext != '0) ? OFFER : IDLE;
            end else begin
               if (toCnt != '1)
                  toCntNext = toCnt + TO_W'(1);
               if ((ACK_TIMEOUT != 0) && (toCnt == TO_W'(ACK_TIMEOUT - 1)))
                  stateNext = DROP;
            end
         end
         DROP: begin
            dropEvent = 1'b1;
            toCntNext = '0;
            stateNext = (countNext != '0) ? OFFER : IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state        <= IDLE;
         toCnt        <= '0;
         overflow_err <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         state <= stateNext;
         toCnt <= toCntNext;
         if (ovfEvent)
            overflow_err <= 1'b1;
         else if (clr_err)
            overflow_err <= 1'b0;
         if (dropEvent)
            timeout_err <= 1'b1;
         else if (clr_err)
            timeout_err <= 1'b0;
      end
   end
endmodule

// File: tb/tb_btn_cmd_sequencer.sv
// Scoreboard bench for btn_cmd_sequencer: dutA (no timeout) carries the command
// stream checks, dutB (ACK_TIMEOUT=8) carries the drop timing checks.
module tb_btn_cmd_sequencer;
   localparam int NB   = 4;
   localparam int CW   = 2;
   localparam int CNTW = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NB-1:0] btnA = '0;
   logic [NB-1:0] btnB = '0;
   logic readyA = 1'b0, readyB = 1'b0, clrA = 1'b0, clrB = 1'b0;
   logic validA, validB, ovfA, ovfB, toA, toB;
   logic [CW-1:0] idA, idB;
   logic [CNTW-1:0] cntA, cntB;

   int checks = 0;
   int errors = 0;
   logic [CW-1:0] expQ[$];

   always #5 clk = ~clk;

   btn_cmd_sequencer #(.NUM_BTNS(NB), .CMD_W(CW), .FIFO_DEPTH(4), .ACK_TIMEOUT(0)) dutA (
      .clk(clk), .rst(rst), .btn_down(btnA), .cmd_valid(validA), .cmd_id(idA),
      .cmd_ready(readyA), .fifo_count(cntA), .overflow_err(ovfA), .timeout_err(toA),
      .clr_err(clrA));

   btn_cmd_sequencer #(.NUM_BTNS(NB), .CMD_W(CW), .FIFO_DEPTH(4), .ACK_TIMEOUT(8)) dutB (
      .clk(clk), .rst(rst), .btn_down(btnB), .cmd_valid(validB), .cmd_id(idB),
      .cmd_ready(readyB), .fifo_count(cntB), .overflow_err(ovfB), .timeout_err(toB),
      .clr_err(clrB));

   task automatic check(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", name, act, req);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic pushExp(input int id);
      expQ.push_back(id[CW-1:0]);
   endtask

   task automatic waitDrain(input string name);
      int n;
      n = 0;
      while (expQ.size() != 0 && n < 100) begin
         tick();
         n++;
      end
      check({name, "_drained"}, expQ.size(), 0);
   endtask

   // Monitor: every accepted handshake on dutA must match the scoreboard head.
   always @(negedge clk) begin
      logic [CW-1:0] e;
      if (!rst && validA && readyA) begin
         if (expQ.size() == 0) begin
            check("cmd_unexpected", int'(idA), -1);
         end else begin
            e = expQ.pop_front();
            check("cmd_id", int'(idA), int'(e));
         end
      end
   end

   initial begin
      #100000;
      errors++;
      $display("FAIL watchdog actual=timeout required=finish");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      tick(3);
      rst = 1'b0;
      tick(2);
      check("rst_valid", int'(validA), 0);
      check("rst_id", int'(idA), 0);
      check("rst_count", int'(cntA), 0);
      check("rst_ovf", int'(ovfA), 0);
      check("rst_to", int'(toA), 0);

      // contention: 0,1,3 from rrPtr=0
      readyA = 1'b1;
      check("rr_start", int'(dutA.rrPtr), 0);
      btnA = 4'b1011;
      pushExp(0); pushExp(1); pushExp(3);
      tick();
      btnA = '0;
      waitDrain("contention");
      tick(2);
      check("rr_after_contention", int'(dutA.rrPtr), 0);
      check("contention_ovf", int'(ovfA), 0);
      check("contention_count", int'(cntA), 0);

      // single press with latency, then held for 500 cycles
      tick(4);
      btnA[2] = 1'b1;
      pushExp(2);
      tick();
      check("press_edgeN_valid", int'(validA), 0);
      tick();
      check("press_valid", int'(validA), 1);
      check("press_id", int'(idA), 2);
      tick();
      check("press_accepted_valid", int'(validA), 0);
      tick(500);
      check("held_count", int'(cntA), 0);
      check("held_queue", expQ.size(), 0);
      btnA = '0;
      tick(3);
      btnA[3] = 1'b1;
      pushExp(3);
      tick();
      btnA = '0;
      waitDrain("btn3");
      tick(2);
      check("rr_after_btn3", int'(dutA.rrPtr), 0);

      // full FIFO, held pending, overflow and clear race
      readyA = 1'b0;
      tick(2);
      for (int b = 0; b < NB; b++) begin
         btnA = '0;
         btnA[b] = 1'b1;
         pushExp(b);
         tick();
         btnA = '0;
         tick(3);
      end
      check("full_count", int'(cntA), 4);
      btnA[0] = 1'b1;
      pushExp(0);
      tick();
      btnA = '0;
      tick(3);
      check("full_count_hold", int'(cntA), 4);
      check("pending0_held", int'(dutA.pending[0]), 1);
      check("ovf_before", int'(ovfA), 0);
      btnA[0] = 1'b1;
      tick();
      check("ovf_set", int'(ovfA), 1);
      check("pending0_still", int'(dutA.pending[0]), 1);
      btnA = '0;
      tick();
      clrA = 1'b1;
      tick();
      clrA = 1'b0;
      check("ovf_clr", int'(ovfA), 0);
      btnA[0] = 1'b1;
      clrA = 1'b1;
      tick();
      check("ovf_race", int'(ovfA), 1);
      tick();
      check("ovf_clr_alone", int'(ovfA), 0);
      clrA = 1'b0;
      btnA = '0;
      check("full_head_valid", int'(validA), 1);
      check("full_head_id", int'(idA), 0);
      readyA = 1'b1;
      waitDrain("full_drain");
      tick(2);
      check("full_drain_count", int'(cntA), 0);

      // timeout on dutB: 8 cycles valid, one DROP cycle
      readyB = 1'b0;
      btnB[1] = 1'b1;
      tick();
      btnB = '0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         check("to_valid_hi", int'(validB), 1);
      end
      check("to_id", int'(idB), 1);
      tick();
      check("to_drop_valid", int'(validB), 0);
      check("to_drop_count", int'(cntB), 1);
      check("to_err_during_drop", int'(toB), 0);
      tick();
      check("to_err", int'(toB), 1);
      check("to_count_after", int'(cntB), 0);
      check("to_valid_after", int'(validB), 0);
      clrB = 1'b1;
      tick();
      clrB = 1'b0;
      check("to_err_clr", int'(toB), 0);

      // reset mid-operation with btn1 held through it
      readyA = 1'b0;
      btnA[0] = 1'b1;
      pushExp(0);
      tick();
      btnA[0] = 1'b0;
      tick(2);
      btnA[1] = 1'b1;
      pushExp(1);
      tick(3);
      btnA[2] = 1'b1;
      pushExp(2);
      tick();
      btnA[2] = 1'b0;
      tick(3);
      check("pre_rst_count", int'(cntA), 3);
      check("pre_rst_valid", int'(validA), 1);
      #2 rst = 1'b1;
      #1;
      check("arst_valid", int'(validA), 0);
      check("arst_id", int'(idA), 0);
      check("arst_count", int'(cntA), 0);
      check("arst_ovf", int'(ovfA), 0);
      expQ.delete();
      tick(2);
      rst = 1'b0;
      readyA = 1'b1;
      tick(20);
      check("held_through_rst_count", int'(cntA), 0);
      check("held_through_rst_valid", int'(validA), 0);
      btnA[1] = 1'b0;
      tick(2);
      btnA[1] = 1'b1;
      pushExp(1);
      tick();
      waitDrain("repress");
      btnA = '0;
      tick(3);

      check("final_queue_empty", expQ.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
